// File: rtl/temp_sense_sequencer.sv
// Periodic temperature acquisition sequencer: triggers the ADC, holds the
// calculator inputs stable while the result settles, then publishes tempc/drd.
module temp_sense_sequencer #(
    parameter int SAMPLE_PERIOD = 1000,
    parameter int ADC_TIMEOUT   = 255,
    parameter int CALC_LAT      = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        enable,
    input  logic        cfg_load,
    input  logic [31:0] cfg_tc_base,
    input  logic [7:0]  cfg_tc_ref,
    input  logic        err_clr,
    output logic        adc_start,
    input  logic        adc_done,
    input  logic [15:0] adc_data_in,
    output logic [31:0] calc_tc_base,
    output logic [7:0]  calc_tc_ref,
    output logic [15:0] calc_adc_data,
    input  logic [31:0] calc_tempc,
    input  logic [31:0] calc_drd,
    output logic [31:0] temp_out,
    output logic [31:0] drd_out,
    output logic        temp_valid,
    output logic [15:0] sample_count,
    output logic        adc_timeout_err,
    output logic        busy
);

    localparam int PW = $clog2(SAMPLE_PERIOD);
    localparam int TW = $clog2(ADC_TIMEOUT + 1);
    localparam int SW = $clog2(CALC_LAT + 1);
    localparam logic [PW-1:0] PERIOD_LAST = PW'(SAMPLE_PERIOD - 1);
    localparam logic [TW-1:0] TMO_LAST    = TW'(ADC_TIMEOUT - 1);
    localparam logic [SW-1:0] SETTLE_LAST = SW'(CALC_LAT - 1);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_CONV,
        ST_CALC,
        ST_WAIT
    } state_t;

    state_t        state_q, state_d;
    logic [PW-1:0] period_q, period_d;
    logic [TW-1:0] tmo_q, tmo_d;
    logic [SW-1:0] settle_q, settle_d;
    logic [31:0]   pend_base_q, pend_base_d;
    logic [7:0]    pend_ref_q, pend_ref_d;
    logic [31:0]   calc_tc_base_q, calc_tc_base_d;
    logic [7:0]    calc_tc_ref_q, calc_tc_ref_d;
    logic [15:0]   calc_adc_data_q, calc_adc_data_d;
    logic [31:0]   temp_out_q, temp_out_d;
    logic [31:0]   drd_out_q, drd_out_d;
    logic          temp_valid_q, temp_valid_d;
    logic [15:0]   sample_count_q, sample_count_d;
    logic          err_q, err_d;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q         <= ST_IDLE;
            period_q        <= '0;
            tmo_q           <= '0;
            settle_q        <= '0;
            pend_base_q     <= '0;
            pend_ref_q      <= '0;
            calc_tc_base_q  <= '0;
            calc_tc_ref_q   <= '0;
            calc_adc_data_q <= '0;
            temp_out_q      <= '0;
            drd_out_q       <= '0;
            temp_valid_q    <= 1'b0;
            sample_count_q  <= '0;
            err_q           <= 1'b0;
        end else begin
            state_q         <= state_d;
            period_q        <= period_d;
            tmo_q           <= tmo_d;
            settle_q        <= settle_d;
            pend_base_q     <= pend_base_d;
            pend_ref_q      <= pend_ref_d;
            calc_tc_base_q  <= calc_tc_base_d;
            calc_tc_ref_q   <= calc_tc_ref_d;
            calc_adc_data_q <= calc_adc_data_d;
            temp_out_q      <= temp_out_d;
            drd_out_q       <= drd_out_d;
            temp_valid_q    <= temp_valid_d;
            sample_count_q  <= sample_count_d;
            err_q           <= err_d;
        end
    end

    always_comb begin
        state_d         = state_q;
        period_d        = (period_q == PERIOD_LAST) ? period_q : period_q + 1'b1;
        tmo_d           = tmo_q;
        settle_d        = settle_q;
        pend_base_d     = pend_base_q;
        pend_ref_d      = pend_ref_q;
        calc_tc_base_d  = calc_tc_base_q;
        calc_tc_ref_d   = calc_tc_ref_q;
        calc_adc_data_d = calc_adc_data_q;
        temp_out_d      = temp_out_q;
        drd_out_d       = drd_out_q;
        temp_valid_d    = 1'b0;
        sample_count_d  = sample_count_q;
        err_d           = err_clr ? 1'b0 : err_q;

        if (cfg_load) begin
            pend_base_d = cfg_tc_base;
            pend_ref_d  = cfg_tc_ref;
        end

        // The period counter is zeroed on the edge into START so it reads 0
        // while adc_start is high, giving exact SAMPLE_PERIOD spacing.
        unique case (state_q)
            ST_IDLE: begin
                if (enable) begin
                    state_d  = ST_START;
                    period_d = '0;
                end
            end
            ST_START: begin
                calc_tc_base_d = pend_base_q;
                calc_tc_ref_d  = pend_ref_q;
                tmo_d          = '0;
                state_d        = ST_CONV;
            end
            ST_CONV: begin
                tmo_d = tmo_q + 1'b1;
                if (adc_done) begin
                    calc_adc_data_d = adc_data_in;
                    settle_d        = '0;
                    state_d         = ST_CALC;
                end else if (tmo_q == TMO_LAST) begin
                    err_d   = 1'b1;
                    state_d = ST_WAIT;
                end
            end
            ST_CALC: begin
                if (settle_q == SETTLE_LAST) begin
                    temp_out_d     = calc_tempc;
                    drd_out_d      = calc_drd;
                    temp_valid_d   = 1'b1;
                    sample_count_d = sample_count_q + 16'd1;
                    state_d        = ST_WAIT;
                end else begin
                    settle_d = settle_q + 1'b1;
                end
            end
            ST_WAIT: begin
                if (period_q == PERIOD_LAST) begin
                    if (enable) begin
                        state_d  = ST_START;
                        period_d = '0;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign adc_start       = (state_q == ST_START);
    assign busy            = (state_q != ST_IDLE);
    assign calc_tc_base    = calc_tc_base_q;
    assign calc_tc_ref     = calc_tc_ref_q;
    assign calc_adc_data   = calc_adc_data_q;
    assign temp_out        = temp_out_q;
    assign drd_out         = drd_out_q;
    assign temp_valid      = temp_valid_q;
    assign sample_count    = sample_count_q;
    assign adc_timeout_err = err_q;

endmodule

// File: tb/tb_temp_sense_sequencer.sv
// Directed bench for temp_sense_sequencer; instance A (short timeout) covers the
// main flow, instance B (long timeout) covers the acquisition-overrun case.
module tb_temp_sense_sequencer;

    localparam int PERIOD = 20;
    localparam int LAT    = 2;

    logic        clk = 1'b0;
    logic        rst_a, rst_b, use_b;
    logic        enable, cfg_load, err_clr, adc_done;
    logic [31:0] cfg_tc_base;
    logic [7:0]  cfg_tc_ref;
    logic [15:0] adc_data_in;

    logic        a_adc_start, a_temp_valid, a_err, a_busy;
    logic [31:0] a_calc_tc_base, a_calc_tempc, a_calc_drd, a_temp_out, a_drd_out;
    logic [7:0]  a_calc_tc_ref;
    logic [15:0] a_calc_adc_data, a_sample_count;

    logic        b_adc_start, b_temp_valid, b_err, b_busy;
    logic [31:0] b_calc_tc_base, b_calc_tempc, b_calc_drd, b_temp_out, b_drd_out;
    logic [7:0]  b_calc_tc_ref;
    logic [15:0] b_calc_adc_data, b_sample_count;

    int checks = 0;
    int errors = 0;

    int          tv_at, tv_count, err_at, end_at;
    logic [31:0] temp_at_valid, drd_at_valid, base_during_conv;
    logic [15:0] count_at_valid;

    always #5 clk = ~clk;

    // Calculator models: tempc = tc_base + adc_data, drd = adc_data - tc_ref.
    assign a_calc_tempc = a_calc_tc_base + {16'd0, a_calc_adc_data};
    assign a_calc_drd   = {16'd0, a_calc_adc_data} - {24'd0, a_calc_tc_ref};
    assign b_calc_tempc = b_calc_tc_base + {16'd0, b_calc_adc_data};
    assign b_calc_drd   = {16'd0, b_calc_adc_data} - {24'd0, b_calc_tc_ref};

    wire        o_adc_start    = use_b ? b_adc_start    : a_adc_start;
    wire        o_temp_valid   = use_b ? b_temp_valid   : a_temp_valid;
    wire        o_err          = use_b ? b_err          : a_err;
    wire        o_busy         = use_b ? b_busy         : a_busy;
    wire [31:0] o_calc_tc_base = use_b ? b_calc_tc_base : a_calc_tc_base;
    wire [31:0] o_temp_out     = use_b ? b_temp_out     : a_temp_out;
    wire [31:0] o_drd_out      = use_b ? b_drd_out      : a_drd_out;
    wire [15:0] o_sample_count = use_b ? b_sample_count : a_sample_count;

    temp_sense_sequencer #(.SAMPLE_PERIOD(PERIOD), .ADC_TIMEOUT(10), .CALC_LAT(LAT)) dut_a (
        .clk(clk), .rst_n(rst_a), .enable(enable), .cfg_load(cfg_load),
        .cfg_tc_base(cfg_tc_base), .cfg_tc_ref(cfg_tc_ref), .err_clr(err_clr),
        .adc_start(a_adc_start), .adc_done(adc_done), .adc_data_in(adc_data_in),
        .calc_tc_base(a_calc_tc_base), .calc_tc_ref(a_calc_tc_ref),
        .calc_adc_data(a_calc_adc_data), .calc_tempc(a_calc_tempc), .calc_drd(a_calc_drd),
        .temp_out(a_temp_out), .drd_out(a_drd_out), .temp_valid(a_temp_valid),
        .sample_count(a_sample_count), .adc_timeout_err(a_err), .busy(a_busy)
    );

    temp_sense_sequencer #(.SAMPLE_PERIOD(PERIOD), .ADC_TIMEOUT(40), .CALC_LAT(LAT)) dut_b (
        .clk(clk), .rst_n(rst_b), .enable(enable), .cfg_load(cfg_load),
        .cfg_tc_base(cfg_tc_base), .cfg_tc_ref(cfg_tc_ref), .err_clr(err_clr),
        .adc_start(b_adc_start), .adc_done(adc_done), .adc_data_in(adc_data_in),
        .calc_tc_base(b_calc_tc_base), .calc_tc_ref(b_calc_tc_ref),
        .calc_adc_data(b_calc_adc_data), .calc_tempc(b_calc_tempc), .calc_drd(b_calc_drd),
        .temp_out(b_temp_out), .drd_out(b_drd_out), .temp_valid(b_temp_valid),
        .sample_count(b_sample_count), .adc_timeout_err(b_err), .busy(b_busy)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        if (observed !== expected) begin
            errors++;
            $display("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
        end
    endtask

    task automatic checkAllZeroA(input string tag);
        checkOutput({tag, " adc_start"}, {31'd0, a_adc_start}, 32'd0);
        checkOutput({tag, " temp_valid"}, {31'd0, a_temp_valid}, 32'd0);
        checkOutput({tag, " busy"}, {31'd0, a_busy}, 32'd0);
        checkOutput({tag, " err"}, {31'd0, a_err}, 32'd0);
        checkOutput({tag, " temp_out"}, a_temp_out, 32'd0);
        checkOutput({tag, " drd_out"}, a_drd_out, 32'd0);
        checkOutput({tag, " sample_count"}, {16'd0, a_sample_count}, 32'd0);
        checkOutput({tag, " calc_tc_base"}, a_calc_tc_base, 32'd0);
        checkOutput({tag, " calc_tc_ref"}, {24'd0, a_calc_tc_ref}, 32'd0);
        checkOutput({tag, " calc_adc_data"}, {16'd0, a_calc_adc_data}, 32'd0);
    endtask

    // Runs one sample period starting in the START cycle (t=0) and stops at the
    // next START or on return to IDLE. Negative cycle arguments disable a hook.
    task automatic applyStimulus(input int k, input logic [15:0] data, input int cfg_at,
                                 input logic [31:0] cfg_base, input logic [7:0] cfg_ref,
                                 input int clr_at, input int en_drop_at, input int stray_at);
        tv_at    = -1;
        tv_count = 0;
        err_at   = -1;
        end_at   = -1;
        for (int t = 1; t <= 100; t++) begin
            tick();
            if (o_temp_valid) begin
                if (tv_at < 0) begin
                    tv_at          = t;
                    temp_at_valid  = o_temp_out;
                    drd_at_valid   = o_drd_out;
                    count_at_valid = o_sample_count;
                end
                tv_count++;
            end
            if (o_err && err_at < 0) err_at = t;
            if (t == k) base_during_conv = o_calc_tc_base;
            if (o_adc_start || !o_busy) begin
                end_at = t;
                break;
            end
            adc_done    = (t == k) || (t == stray_at);
            adc_data_in = (t == k) ? data : 16'hDEAD;
            cfg_load    = (t == cfg_at);
            cfg_tc_base = cfg_base;
            cfg_tc_ref  = cfg_ref;
            err_clr     = (t == clr_at);
            if (t == en_drop_at) enable = 1'b0;
        end
        adc_done = 1'b0;
        cfg_load = 1'b0;
        err_clr  = 1'b0;
    endtask

    logic [15:0] seq_data [4] = '{16'd100, 16'd200, 16'd300, 16'd400};
    logic [31:0] seq_temp [4] = '{32'd108, 32'hAAAA_AB72, 32'hAAAA_ABD6, 32'hAAAA_AC3A};
    logic [31:0] seq_drd  [4] = '{32'd84, 32'd115, 32'd215, 32'd315};
    logic [31:0] seq_base [4] = '{32'd8, 32'hAAAA_AAAA, 32'hAAAA_AAAA, 32'hAAAA_AAAA};

    initial begin
        rst_a = 1'b0; rst_b = 1'b0; use_b = 1'b0;
        enable = 1'b1; cfg_load = 1'b1; cfg_tc_base = 32'h1234; cfg_tc_ref = 8'h12;
        err_clr = 1'b0; adc_done = 1'b0; adc_data_in = 16'h0;
        repeat (3) tick();
        checkAllZeroA("reset");

        rst_a = 1'b1; cfg_load = 1'b1; cfg_tc_base = 32'd8; cfg_tc_ref = 8'd16; enable = 1'b0;
        tick();
        cfg_load = 1'b0; enable = 1'b1;
        tick();
        checkOutput("first adc_start", {31'd0, a_adc_start}, 32'd1);

        applyStimulus(3, 16'd8, -1, 32'd0, 8'd0, -1, -1, -1);
        checkOutput("basic tv latency", tv_at, 32'd6);
        checkOutput("basic temp_out", temp_at_valid, 32'd16);
        checkOutput("basic drd_out", drd_at_valid, 32'hFFFF_FFF8);
        checkOutput("basic count", {16'd0, count_at_valid}, 32'd1);
        checkOutput("basic tv pulses", tv_count, 32'd1);
        checkOutput("basic base in conv", base_during_conv, 32'd8);
        checkOutput("basic calc_tc_ref", {24'd0, a_calc_tc_ref}, 32'd16);
        checkOutput("basic spacing", end_at, PERIOD);

        for (int i = 0; i < 4; i++) begin
            applyStimulus(3, seq_data[i], (i == 0) ? 2 : -1, 32'hAAAA_AAAA, 8'h55, -1, -1, -1);
            checkOutput($sformatf("seq%0d base in conv", i), base_during_conv, seq_base[i]);
            checkOutput($sformatf("seq%0d temp_out", i), temp_at_valid, seq_temp[i]);
            checkOutput($sformatf("seq%0d drd_out", i), drd_at_valid, seq_drd[i]);
            checkOutput($sformatf("seq%0d count", i), {16'd0, count_at_valid}, i + 2);
            checkOutput($sformatf("seq%0d spacing", i), end_at, PERIOD);
        end

        applyStimulus(-1, 16'd0, -1, 32'hAAAA_AAAA, 8'h55, -1, -1, -1);
        checkOutput("tmo err cycle", err_at, 32'd11);
        checkOutput("tmo no publish", tv_count, 32'd0);
        checkOutput("tmo spacing", end_at, PERIOD);
        checkOutput("tmo count held", {16'd0, a_sample_count}, 32'd5);
        checkOutput("tmo adc_data held", {16'd0, a_calc_adc_data}, 32'd400);

        applyStimulus(3, 16'd50, -1, 32'hAAAA_AAAA, 8'h55, 1, -1, 10);
        checkOutput("err cleared", {31'd0, a_err}, 32'd0);
        checkOutput("stray tv pulses", tv_count, 32'd1);
        checkOutput("stray temp_out", a_temp_out, 32'hAAAA_AADC);
        checkOutput("stray drd_out", a_drd_out, 32'hFFFF_FFDD);
        checkOutput("stray count", {16'd0, a_sample_count}, 32'd6);

        applyStimulus(3, 16'd7, -1, 32'hAAAA_AAAA, 8'h55, -1, 1, -1);
        checkOutput("disable publishes", tv_count, 32'd1);
        checkOutput("disable temp_out", temp_at_valid, 32'hAAAA_AAB1);
        checkOutput("disable idle cycle", end_at, PERIOD);
        checkOutput("disable busy", {31'd0, a_busy}, 32'd0);
        repeat (5) tick();
        checkOutput("disable stays idle", {31'd0, a_busy | a_adc_start}, 32'd0);
        checkOutput("disable count", {16'd0, a_sample_count}, 32'd7);

        enable = 1'b1;
        tick();
        checkOutput("restart adc_start", {31'd0, a_adc_start}, 32'd1);
        for (int t = 1; t <= 4; t++) begin
            tick();
            adc_done    = (t == 3);
            adc_data_in = 16'd9;
        end
        rst_a = 1'b0;
        tick();
        checkAllZeroA("calc reset");
        tick();
        checkAllZeroA("calc reset hold");

        rst_b = 1'b1; use_b = 1'b1; enable = 1'b1;
        tick();
        checkOutput("ovr adc_start", {31'd0, b_adc_start}, 32'd1);
        applyStimulus(30, 16'd5, -1, 32'd0, 8'd0, -1, -1, -1);
        checkOutput("ovr tv latency", tv_at, 32'd33);
        checkOutput("ovr temp_out", temp_at_valid, 32'd5);
        checkOutput("ovr spacing", end_at, 32'd34);
        checkOutput("ovr no err", {31'd0, b_err}, 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
